// File: rtl/fifo_uart_drain_pkg.sv
// Shared types and defaults for the FIFO-to-UART drain block.
package fifo_uart_drain_pkg;

    localparam int DSIZE_DEFAULT        = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 16;

    // Drain FSM state encoding, kept as plain constants for legacy tools.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_POP   = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_START = 3'd3;
    localparam state_t ST_DATA  = 3'd4;
    localparam state_t ST_STOP  = 3'd5;

endpackage

// File: rtl/fifo_uart_drain_if.sv
// Read side of a FIFO with a registered read port: rdata is valid the cycle after rinc.
interface fifo_uart_drain_if
    import fifo_uart_drain_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEFAULT
);
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;

    // The drain pops the FIFO.
    modport master (input rempty, input rdata, output rinc);
    // The FIFO answers pops.
    modport slave (output rempty, output rdata, input rinc);

endinterface

// File: rtl/fifo_uart_drain_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count.
module baud_tick
    import fifo_uart_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = (cnt == 8'(CLKS_PER_BIT - 1));

    // Advance the bit counter; restart makes the first cycle of every new state count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops bytes from a FIFO and sends each as an 8N1 frame (LSB first, idle high) on txd.
module fifo_uart_drain
    import fifo_uart_drain_pkg::*;
#(
    parameter int DSIZE        = DSIZE_DEFAULT,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    fifo_uart_drain_if.master        fifo,
    output logic                     txd,
    output logic                     busy,
    output logic [7:0]               frame_cnt
);

    localparam int IW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DSIZE - 1);

    state_t           state;
    state_t           state_next;
    logic             armed;
    logic             tick;
    logic             restart;
    logic [DSIZE-1:0] shreg;
    logic [DSIZE-1:0] shreg_nxt;
    logic [IW-1:0]    bit_idx;

    assign shreg_nxt = shreg >> 1;
    assign restart   = (state_next != state);
    assign busy      = (state != ST_IDLE);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .tick   (tick)
    );

    // Next-state logic; armed holds off the first pop until one full cycle after reset release.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_IDLE:  if (armed && en && !fifo.rempty) state_next = ST_POP;
            ST_POP:   state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_START;
            ST_START: if (tick) state_next = ST_DATA;
            ST_DATA:  if (tick && (bit_idx == LAST_BIT)) state_next = ST_STOP;
            ST_STOP:  if (tick) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, pop strobe, shift register, serial output and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            armed     <= 1'b0;
            fifo.rinc <= 1'b0;
            txd       <= 1'b1;
            shreg     <= '0;
            bit_idx   <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_next;
            armed     <= 1'b1;
            // Only IDLE can lead to POP, so this is a single-cycle strobe per frame.
            fifo.rinc <= (state_next == ST_POP);
            case (state)
                ST_WAIT: begin
                    // rdata is valid now; once captured, FIFO activity cannot disturb the frame.
                    shreg <= fifo.rdata;
                    txd   <= 1'b0;
                end
                ST_START: begin
                    if (tick) begin
                        txd     <= shreg[0];
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
                            txd <= 1'b1;
                        end else begin
                            txd     <= shreg_nxt[0];
                            shreg   <= shreg_nxt;
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) frame_cnt <= frame_cnt + 8'd1;
                end
                default: txd <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain: a FIFO model feeds bytes and the serial line is decoded cycle by cycle.
module tb_fifo_uart_drain;
    import fifo_uart_drain_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       txd;
    logic       busy;
    logic [7:0] frame_cnt;

    logic       rst_n_f = 1'b0;
    logic       en_f    = 1'b0;
    logic       txd_f;
    logic       busy_f;
    logic [7:0] frame_cnt_f;

    int tests_run = 0;
    int tests_failed = 0;

    fifo_uart_drain_if #(.DSIZE(8)) fif ();
    fifo_uart_drain_if #(.DSIZE(8)) fif_f ();

    fifo_uart_drain #(.DSIZE(8), .CLKS_PER_BIT(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo(fif),
        .txd(txd), .busy(busy), .frame_cnt(frame_cnt)
    );

    // Fast instance for the frame-counter wrap: FIFO never empty, constant data.
    fifo_uart_drain #(.DSIZE(8), .CLKS_PER_BIT(2)) dut_fast (
        .clk(clk), .rst_n(rst_n_f), .en(en_f), .fifo(fif_f),
        .txd(txd_f), .busy(busy_f), .frame_cnt(frame_cnt_f)
    );

    assign fif_f.rempty = 1'b0;
    assign fif_f.rdata  = 8'h5A;

    always #5 clk = ~clk;

    // FIFO model with registered read, plus pop statistics.
    logic [7:0] mem [0:15];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    int   rinc_total = 0;
    int   pop_empty = 0;
    int   rinc_double = 0;
    logic rinc_q = 1'b0;

    always @(posedge clk) begin
        if (fif.rinc === 1'b1) begin
            rinc_total <= rinc_total + 1;
            if (rinc_q) rinc_double <= rinc_double + 1;
            if (rd_ptr == wr_ptr) begin
                pop_empty <= pop_empty + 1;
            end else begin
                fif.rdata <= mem[rd_ptr[3:0]];
                rd_ptr    <= rd_ptr + 1;
            end
        end
        rinc_q <= fif.rinc;
    end

    always @(negedge clk) fif.rempty <= (rd_ptr == wr_ptr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[3:0]] = b;
        wr_ptr++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Starting at a negedge, wait for a start bit, then sample ten 16-cycle bit windows.
    task automatic rx_frame(output logic [9:0] bits, output logic steady, output logic started);
        int   n = 0;
        logic first;
        bits   = '0;
        steady = 1'b1;
        while (txd !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        started = (txd === 1'b0);
        if (!started) return;
        for (int b = 0; b < 10; b++) begin
            first   = txd;
            bits[b] = first;
            for (int c = 0; c < 16; c++) begin
                if (txd !== first) steady = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] b);
        logic [9:0] bits;
        logic       steady;
        logic       started;
        rx_frame(bits, steady, started);
        check({tag, "_start"}, 32'(started), 1);
        check({tag, "_bits"}, 32'(bits), 32'({1'b1, b, 1'b0}));
        check({tag, "_steady"}, 32'(steady), 1);
    endtask

    // Count idle-high cycles from the current negedge up to the next start bit.
    task automatic count_high(output int n);
        n = 0;
        while (txd === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   bad;
        int   r0;
        int   gap;
        int   n;
        int   fr;
        logic prev;

        // Reset values, then 100 cycles enabled against an empty FIFO.
        en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_txd", 32'(txd), 1);
        check("rst_rinc", 32'(fif.rinc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1 || fif.rinc !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd0) bad++;
        end
        check("idle_empty", bad, 0);

        // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, stop.
        r0 = rinc_total;
        push(8'hA5);
        expect_frame("a5", 8'hA5);
        check("a5_frame_cnt", 32'(frame_cnt), 1);
        check("a5_busy", 32'(busy), 0);
        check("a5_rinc", rinc_total - r0, 1);
        check("a5_rinc_width", rinc_double, 0);

        // Back-to-back frames from a preloaded FIFO after reset.
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        r0 = rinc_total;
        do_reset();
        @(negedge clk);
        check("early_pop", 32'(fif.rinc), 0);
        expect_frame("b2b0", 8'h00);
        count_high(gap);
        check("b2b_gap1", gap, 3);
        expect_frame("b2b1", 8'hFF);
        count_high(gap);
        check("b2b_gap2", gap, 3);
        expect_frame("b2b2", 8'h3C);
        check("b2b_frame_cnt", 32'(frame_cnt), 3);
        check("b2b_rinc", rinc_total - r0, 3);
        check("b2b_pop_empty", pop_empty, 0);

        // Enable dropped during DATA with a second byte still queued.
        push(8'h81);
        push(8'h42);
        r0 = rinc_total;
        do_reset();
        fork
            expect_frame("drop", 8'h81);
            begin
                repeat (60) @(negedge clk);
                en = 1'b0;
            end
        join
        check("drop_frame_cnt", 32'(frame_cnt), 1);
        check("drop_busy", 32'(busy), 0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || fif.rinc !== 1'b0 || txd !== 1'b1) bad++;
        end
        check("drop_quiet", bad, 0);
        check("drop_rinc", rinc_total - r0, 1);

        // Reset in the middle of DATA bit 4 of 0x42 (a 0 bit); that byte is lost.
        en = 1'b1;
        do_reset();
        n = 0;
        while (txd !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_start", 32'(txd === 1'b0), 1);
        repeat (88) @(negedge clk);
        check("mid_pre_txd", 32'(txd), 0);
        check("mid_pre_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd", 32'(txd), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        push(8'h96);
        rst_n = 1'b1;
        expect_frame("after_rst", 8'h96);
        check("after_rst_frame_cnt", 32'(frame_cnt), 1);

        // Frame counter wrap: 256 frames at 2 clocks per bit.
        en   = 1'b0;
        @(negedge clk);
        rst_n_f = 1'b1;
        en_f    = 1'b1;
        fr   = 0;
        n    = 0;
        prev = 1'b0;
        while (fr < 256 && n < 20000) begin
            @(negedge clk);
            n++;
            if (prev && !busy_f) begin
                fr++;
                if (fr == 1)   check("wrap_first", 32'(frame_cnt_f), 1);
                if (fr == 255) check("wrap_255", 32'(frame_cnt_f), 255);
                if (fr == 256) check("wrap_0", 32'(frame_cnt_f), 0);
            end
            prev = busy_f;
        end
        check("wrap_frames", fr, 256);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
